// File: rtl/core_sequencer.sv
// ----------------------------------------------------------------------------
// core_sequencer
//
// Multi-cycle fetch/execute controller for the LemonPC core. Each instruction
// is fetched over a request/acknowledge port and captured in the instruction
// register. It is then held for one EXEC cycle. In that cycle the register
// file may be written once, and the PC and retired-instruction count advance.
// Executing ebreak parks the core in a terminal HALT state. Only reset leaves
// HALT.
//
// Ports
//   clk          in   1     sole clock, rising edge
//   rst_n        in   1     asynchronous active-low reset
//   run          in   1     permits starting a new fetch (sampled in IDLE/EXEC)
//   ifetch_req   out  1     fetch request, held until acknowledged
//   ifetch_addr  out  XLEN  fetch address, always equal to pc
//   ifetch_ack   in   1     one-cycle acknowledge, ifetch_data valid with it
//   ifetch_data  in   32    fetched instruction
//   inst         out  32    instruction register feeding decode/regfile/ALU
//   dec_ebreak   in   1     decoder flag for inst == ebreak
//   dec_wen      in   1     decoder flag: inst writes rd
//   rf_wen       out  1     register-file write enable, only ever in EXEC
//   pc           out  XLEN  address of the instruction held in inst
//   halted       out  1     high once ebreak has executed
//   instret      out  XLEN  retired-instruction count
// ----------------------------------------------------------------------------
module core_sequencer #(
   parameter int               XLEN     = 64,
   parameter logic [XLEN-1:0]  RESET_PC = 'h8000_0000,
   parameter logic [31:0]      NOP_INST = 32'h0000_0013
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   output logic              ifetch_req,
   output logic [XLEN-1:0]   ifetch_addr,
   input  logic              ifetch_ack,
   input  logic [31:0]       ifetch_data,
   output logic [31:0]       inst,
   input  logic              dec_ebreak,
   input  logic              dec_wen,
   output logic              rf_wen,
   output logic [XLEN-1:0]   pc,
   output logic              halted,
   output logic [XLEN-1:0]   instret
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t state;
   state_t state_next;

   // Strobes from the next-state logic that tell the datapath registers when
   // to load.
   logic inst_load;
   logic retire;

   // -------------------------------------------------------------------------
   // Next-state and output decode
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of this block gets a default first. If any path
      // left one unassigned, synthesis would infer a latch to hold it.
      state_next = state;
      ifetch_req = 1'b0;
      rf_wen     = 1'b0;
      halted     = 1'b0;
      inst_load  = 1'b0;
      retire     = 1'b0;

      unique case (state)
         IDLE: begin
            if (run) state_next = FETCH;
         end

         FETCH: begin
            // An issued request is never abandoned. run is not looked at
            // here, so the request stays up until the ack arrives.
            ifetch_req = 1'b1;
            if (ifetch_ack) begin
               inst_load  = 1'b1;
               state_next = EXEC;
            end
         end

         EXEC: begin
            if (dec_ebreak) begin
               // ebreak does not retire. pc keeps pointing at the ebreak
               // so a debugger can see where execution stopped.
               state_next = HALT;
            end else begin
               rf_wen     = dec_wen;
               retire     = 1'b1;
               state_next = run ? FETCH : IDLE;
            end
         end

         HALT: begin
            halted = 1'b1;
         end

         default: state_next = IDLE;
      endcase
   end

   // The fetch address is the PC by construction. It is stable for the whole
   // FETCH interval because pc only moves on the edge that leaves EXEC.
   assign ifetch_addr = pc;

   // -------------------------------------------------------------------------
   // State and datapath registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         pc      <= RESET_PC;
         inst    <= NOP_INST;
         instret <= '0;
      end else begin
         // NOTE: clocked state uses non-blocking assignments. Every register
         // here then samples values from before the edge, so the order of
         // the statements does not matter.
         state <= state_next;
         if (inst_load) inst <= ifetch_data;
         if (retire) begin
            // Both additions wrap modulo 2^XLEN with no extra logic.
            pc      <= pc + XLEN'(4);
            instret <= instret + XLEN'(1);
         end
      end
   end

endmodule

// File: tb/tb_core_sequencer.sv
// ----------------------------------------------------------------------------
// tb_core_sequencer
//
// Directed and randomized bench for core_sequencer. The reference model tracks
// only architectural quantities: expected pc, instret and halted, plus the
// write enable an instruction should produce. Each instruction is one fetch
// transaction. The model advances those quantities with plain arithmetic.
// A second instance whose reset PC sits just below 2^64 covers PC wrap.
// ----------------------------------------------------------------------------
module tb_core_sequencer;

   localparam logic [63:0] RESET_PC = 64'h8000_0000;
   localparam logic [63:0] WRAP_PC  = 64'hFFFF_FFFF_FFFF_FFFC;
   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam logic [31:0] ADDI     = 32'h0010_8093;
   localparam logic [31:0] EBREAK   = 32'h0010_0073;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        run;
   logic        ifetch_req;
   logic [63:0] ifetch_addr;
   logic        ifetch_ack;
   logic [31:0] ifetch_data;
   logic [31:0] inst;
   logic        dec_ebreak;
   logic        dec_wen;
   logic        rf_wen;
   logic [63:0] pc;
   logic        halted;
   logic [63:0] instret;

   // Signals of the wrap-test instance
   logic        w_run;
   logic        w_req;
   logic [63:0] w_addr;
   logic        w_ack;
   logic [31:0] w_data;
   logic [31:0] w_inst;
   logic        w_ebreak;
   logic        w_wen;
   logic        w_rf_wen;
   logic [63:0] w_pc;
   logic        w_halted;
   logic [63:0] w_instret;

   int vectors     = 0;
   int miscompares = 0;
   int cyc_cnt     = 0;

   // Reference model state
   logic [63:0] m_pc;
   logic [63:0] m_instret;
   logic        m_halted;
   int          wen_cycles[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // Stand-in decoder. Stores and branches do not write rd; everything else
   // does, ebreak included. That makes the rf_wen gating on ebreak visible.
   function automatic logic wen_of(input logic [31:0] i);
      return !(i[6:0] == 7'b0100011 || i[6:0] == 7'b1100011);
   endfunction

   assign dec_ebreak = (inst == EBREAK);
   assign dec_wen    = wen_of(inst);
   assign w_ebreak   = (w_inst == EBREAK);
   assign w_wen      = wen_of(w_inst);

   core_sequencer u_dut (
      .clk(clk), .rst_n(rst_n), .run(run),
      .ifetch_req(ifetch_req), .ifetch_addr(ifetch_addr),
      .ifetch_ack(ifetch_ack), .ifetch_data(ifetch_data),
      .inst(inst), .dec_ebreak(dec_ebreak), .dec_wen(dec_wen),
      .rf_wen(rf_wen), .pc(pc), .halted(halted), .instret(instret)
   );

   core_sequencer #(.RESET_PC(WRAP_PC)) u_wrap (
      .clk(clk), .rst_n(rst_n), .run(w_run),
      .ifetch_req(w_req), .ifetch_addr(w_addr),
      .ifetch_ack(w_ack), .ifetch_data(w_data),
      .inst(w_inst), .dec_ebreak(w_ebreak), .dec_wen(w_wen),
      .rf_wen(w_rf_wen), .pc(w_pc), .halted(w_halted), .instret(w_instret)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock. Inputs change and outputs are sampled at the negedge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_req();
      int n = 0;
      while (ifetch_req !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      check("req_timeout", ifetch_req, 1'b1);
   endtask

   task automatic model_reset();
      m_pc      = RESET_PC;
      m_instret = '0;
      m_halted  = 1'b0;
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      run        = 1'b0;
      ifetch_ack = 1'b0;
      #2;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   // One fetch/execute transaction against the model
   task automatic exec_inst(input logic [31:0] data, input int waits,
                            input bit spurious, input bit drop_run);
      logic is_eb;
      is_eb = (data == EBREAK);
      wait_req();
      check("fetch_addr", ifetch_addr, m_pc);
      check("fetch_pc", pc, m_pc);
      for (int i = 0; i < waits; i++) begin
         check("wait_req", ifetch_req, 1'b1);
         check("wait_addr", ifetch_addr, m_pc);
         step();
      end
      ifetch_data = data;
      ifetch_ack  = 1'b1;
      step();
      ifetch_ack  = 1'b0;
      // EXEC cycle
      check("exec_inst", inst, data);
      check("exec_rf_wen", rf_wen, is_eb ? 1'b0 : wen_of(data));
      check("exec_req", ifetch_req, 1'b0);
      check("exec_pc", pc, m_pc);
      if (rf_wen) wen_cycles.push_back(cyc_cnt);
      if (spurious) begin
         ifetch_ack  = 1'b1;
         ifetch_data = ~data;
      end
      if (drop_run) run = 1'b0;
      step();
      ifetch_ack = 1'b0;
      if (is_eb) m_halted = 1'b1;
      else begin
         m_pc      = m_pc + 64'd4;
         m_instret = m_instret + 64'd1;
      end
      check("post_inst", inst, data);
      check("post_pc", pc, m_pc);
      check("post_instret", instret, m_instret);
      check("post_halted", halted, m_halted);
      check("post_rf_wen", rf_wen, 1'b0);
      if (drop_run && !is_eb) begin
         check("idle_req0", ifetch_req, 1'b0);
         step();
         check("idle_req1", ifetch_req, 1'b0);
         run = 1'b1;
         check("idle_req2", ifetch_req, 1'b0);
         step();
         check("restart_req", ifetch_req, 1'b1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      rst_n       = 1'b0;
      run         = 1'b0;
      ifetch_ack  = 1'b0;
      ifetch_data = '0;
      w_run       = 1'b0;
      w_ack       = 1'b0;
      w_data      = '0;
      model_reset();

      // Reset values held for 10 cycles with run low
      step();
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         check("rst_pc", pc, RESET_PC);
         check("rst_inst", inst, NOP);
         check("rst_req", ifetch_req, 1'b0);
         check("rst_instret", instret, 64'd0);
         check("rst_rf_wen", rf_wen, 1'b0);
         check("rst_halted", halted, 1'b0);
         step();
      end

      // Zero-wait fetch of three addi: writes spaced two cycles apart
      run = 1'b1;
      wen_cycles.delete();
      for (int i = 0; i < 3; i++) exec_inst(ADDI, 0, 1'b0, 1'b0);
      check("zw_wen_count", 64'(wen_cycles.size()), 64'd3);
      if (wen_cycles.size() == 3) begin
         check("zw_spacing0", 64'(wen_cycles[1] - wen_cycles[0]), 64'd2);
         check("zw_spacing1", 64'(wen_cycles[2] - wen_cycles[1]), 64'd2);
      end
      check("zw_pc", pc, 64'h8000_000C);
      check("zw_instret", instret, 64'd3);

      // Randomized program: wait states, spurious acks, run dropped in EXEC
      for (int k = 0; k < 16; k++) begin
         d = $urandom;
         if (d == EBREAK) d = d ^ 32'h1;
         exec_inst(d, (k == 0) ? 5 : int'($urandom_range(0, 4)),
                   (k == 0) ? 1'b1 : 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0));
      end

      // Halt on ebreak at 0x8000_0008
      do_reset();
      run = 1'b1;
      exec_inst(ADDI, 0, 1'b0, 1'b0);
      exec_inst(ADDI, 1, 1'b0, 1'b0);
      check("halt_at_pc", pc, 64'h8000_0008);
      exec_inst(EBREAK, 0, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) begin
         ifetch_ack  = 1'($urandom_range(0, 1));
         ifetch_data = $urandom;
         step();
         check("halt_req", ifetch_req, 1'b0);
         check("halt_flag", halted, 1'b1);
         check("halt_pc", pc, 64'h8000_0008);
         check("halt_rf_wen", rf_wen, 1'b0);
         check("halt_inst", inst, EBREAK);
      end
      ifetch_ack = 1'b0;

      // Asynchronous reset in the middle of FETCH
      do_reset();
      run = 1'b1;
      wait_req();
      step();
      check("midf_req_before", ifetch_req, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("midf_req", ifetch_req, 1'b0);
      check("midf_pc", pc, RESET_PC);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      // Asynchronous reset in the middle of EXEC
      run = 1'b1;
      exec_inst(ADDI, 0, 1'b0, 1'b0);
      wait_req();
      ifetch_data = ADDI;
      ifetch_ack  = 1'b1;
      step();
      ifetch_ack  = 1'b0;
      check("mide_rf_wen_before", rf_wen, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("mide_rf_wen", rf_wen, 1'b0);
      check("mide_req", ifetch_req, 1'b0);
      check("mide_pc", pc, RESET_PC);
      check("mide_instret", instret, 64'd0);
      check("mide_inst", inst, NOP);
      @(negedge clk);
      rst_n = 1'b1;
      run   = 1'b0;
      model_reset();

      // PC wrap on the second instance, with run dropped during EXEC
      w_run = 1'b1;
      for (int n = 0; n < 20 && w_req !== 1'b1; n++) step();
      check("wrap_req", w_req, 1'b1);
      check("wrap_addr", w_addr, WRAP_PC);
      w_data = ADDI;
      w_ack  = 1'b1;
      step();
      w_ack  = 1'b0;
      check("wrap_rf_wen", w_rf_wen, 1'b1);
      w_run = 1'b0;
      step();
      check("wrap_pc", w_pc, 64'd0);
      check("wrap_instret", w_instret, 64'd1);
      for (int i = 0; i < 3; i++) begin
         check("wrap_idle_req", w_req, 1'b0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
